// File: rtl/xrisc_muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: one radix-2 step per cycle,
// fixed XLEN+2 cycle occupancy, start/busy/done handshake with kill abort.
module xrisc_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  // Handshake: start is taken on an edge only in IDLE with kill low; busy is high
  // in CALC and FIX; done is a one-cycle pulse in the first IDLE cycle after FIX.
  state_t          state;
  logic [CW-1:0]   count;
  logic [2:0]      op_q;
  logic [XLEN-1:0] mag_a, mag_b, hi, lo;
  logic            sign_a, neg_res, b_zero;

  logic            in_sa, in_sb;
  logic [XLEN-1:0] in_mag_a, in_mag_b;
  logic [XLEN:0]   add_sum, shifted, diff;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] quo, rem, fix_val;

  always_comb begin
    in_sa    = a[XLEN-1] & (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110);
    in_sb    = b[XLEN-1] & (op == 3'b001 || op == 3'b100 || op == 3'b110);
    in_mag_a = in_sa ? -a : a;
    in_mag_b = in_sb ? -b : b;
  end

  always_comb begin
    add_sum = {1'b0, hi} + (lo[0] ? {1'b0, mag_a} : '0);
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, mag_b};
  end

  // MIN_INT / -1 needs no special branch: magnitudes give 2^(XLEN-1) / 1 with
  // both signs negative, so the quotient stays MIN_INT and the remainder 0.
  always_comb begin
    prod    = {hi, lo};
    prod_s  = neg_res ? -prod : prod;
    quo     = neg_res ? -lo : lo;
    rem     = sign_a ? -hi : hi;
    fix_val = '0;
    case (op_q)
      3'b000:                 fix_val = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_val = b_zero ? '1 : quo;
      default:                fix_val = b_zero ? (sign_a ? -mag_a : mag_a) : rem;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      op_q    <= '0;
      mag_a   <= '0;
      mag_b   <= '0;
      hi      <= '0;
      lo      <= '0;
      sign_a  <= 1'b0;
      neg_res <= 1'b0;
      b_zero  <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !kill) begin
            op_q    <= op;
            mag_a   <= in_mag_a;
            mag_b   <= in_mag_b;
            sign_a  <= in_sa;
            neg_res <= in_sa ^ in_sb;
            b_zero  <= (b == '0);
            hi      <= '0;
            lo      <= op[2] ? in_mag_a : in_mag_b;
            count   <= CW'(XLEN);
            state   <= CALC;
          end
        end
        CALC: begin
          if (kill) begin
            state <= IDLE;
          end else begin
            if (!op_q[2]) begin
              hi <= add_sum[XLEN:1];
              lo <= {add_sum[0], lo[XLEN-1:1]};
            end else if (!diff[XLEN]) begin
              hi <= diff[XLEN-1:0];
              lo <= {lo[XLEN-2:0], 1'b1};
            end else begin
              hi <= shifted[XLEN-1:0];
              lo <= {lo[XLEN-2:0], 1'b0};
            end
            count <= count - 1'b1;
            if (count == CW'(1)) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!kill) begin
            result <= fix_val;
            done   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xrisc_muldiv_unit.sv
// Directed and randomized bench for xrisc_muldiv_unit with an arithmetic reference model.
module tb_xrisc_muldiv_unit;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            kill = 1'b0;
  logic [2:0]      op = '0;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            busy, done;
  logic [XLEN-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  xrisc_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    longint unsigned ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * longint'(uy); return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == MIN_INT && y == 32'hFFFF_FFFF) return MIN_INT;
        return 32'(sx / sy);
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == MIN_INT && y == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sx % sy);
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return MIN_INT;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where done is seen (or timeout).
  // stray_at >= 0 pulses a second start while the op is in flight.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int stray_at, input string tag);
    int edges, busy_cycles;
    exp_q.push_back(ref_model(o, x, y));
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    edges = 0;
    busy_cycles = int'(busy);
    while (!done && edges < 60) begin
      start = (edges == stray_at);
      @(negedge clk);
      edges++;
      busy_cycles += int'(busy);
    end
    start = 1'b0;
    check({tag, "_latency"}, edges, 33);
    check({tag, "_busy_cycles"}, busy_cycles, 33);
    check({tag, "_result"}, result, exp_q.pop_front());
  endtask

  initial begin
    logic [31:0] prev_res;
    bit seen_done;

    // Reset
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_result", result, 0);

    // Basic multiply with single done pulse
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, -1, "mul_7_m3");
    check("mul_7_m3_expect", result, 32'hFFFF_FFEB);
    @(negedge clk);
    check("done_single_pulse", 32'(done), 0);

    // High-half multiplies and MUL wrap
    run_op(3'd1, MIN_INT, MIN_INT, -1, "mulh_min");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "mulhu_ones");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "mulhsu_ones");
    run_op(3'd0, MIN_INT, MIN_INT, -1, "mul_min");

    // Division rounding and remainder sign
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, -1, "div_m7_2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, -1, "rem_m7_2");
    run_op(3'd5, 32'd100, 32'd7, -1, "divu_100_7");
    run_op(3'd7, 32'd100, 32'd7, -1, "remu_100_7");

    // Divide by zero and signed overflow
    run_op(3'd5, 32'd5, 32'd0, -1, "divu_by0");
    run_op(3'd7, 32'd5, 32'd0, -1, "remu_by0");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd0, -1, "div_neg_by0");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd0, -1, "rem_neg_by0");
    run_op(3'd4, MIN_INT, 32'hFFFF_FFFF, -1, "div_ovf");
    run_op(3'd6, MIN_INT, 32'hFFFF_FFFF, -1, "rem_ovf");

    // Start while busy is ignored; start in the done cycle is accepted
    @(negedge clk);
    run_op(3'd5, 32'd100, 32'd7, 5, "divu_stray");
    check("divu_stray_14", result, 32'd14);
    run_op(3'd0, 32'd3, 32'd3, -1, "mul_b2b");
    check("mul_b2b_9", result, 32'd9);

    // Kill mid-op
    @(negedge clk);
    prev_res = result;
    op = 3'd4; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", 32'(busy), 0);
    seen_done = 1'b0;
    repeat (40) begin
      seen_done |= done;
      @(negedge clk);
    end
    check("kill_no_done", 32'(seen_done), 0);
    check("kill_result_held", result, prev_res);

    // Kill and start together in IDLE: start dropped
    op = 3'd0; a = 32'd5; b = 32'd5; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("kill_start_idle", 32'(busy), 0);

    // Reset mid-op
    op = 3'd0; a = 32'd11; b = 32'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_result", result, 0);
    run_op(3'd0, 32'd11, 32'd13, -1, "after_rst");

    // Randomized ops, sometimes back-to-back
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : -1, "rand");
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
